alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU functional-unit interface: accepts one command at a time over a valid/ready handshake and drives the shared A/B/OP operand bus. It pulses the enable of exactly one selected unit (arith, logic, cmp or shift), then waits for that unit's registered result flag. It captures the unit's output and returns it on a valid/ready response port, with a timeout error if the flag never arrives.

Parameters:
in_width, 16, operand width of A/B and cmd_A/cmd_B
out_width, 16, result width of unit outputs and rsp_data
TIMEOUT, 7, max WAIT cycles without flag before error; legal range >= 1

Ports:
CLK  in  1  clock, all flops posedge
RST  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
cmd_A  in  in_width  operand A
cmd_B  in  in_width  operand B
cmd_unit  in  2  unit select: 00 arith, 01 logic, 10 cmp, 11 shift
cmd_OP  in  2  operation code passed to the unit
A  out  in_width  operand bus to units
B  out  in_width  operand bus to units
OP  out  2  opcode bus to units
arith_enable, logic_enable, cmp_enable, shift_enable  out  1 each  unit enables
arith_out, logic_out, cmp_out, shift_out  in  out_width each  unit results
arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  unit result-valid flags, registered in the unit
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at posedge
rsp_data  out  out_width  captured result; 0 on error
rsp_err  out  1  1 = timeout, no flag from selected unit

Behaviour:
- Reset (RST high, async): state IDLE; A, B, OP, rsp_data = 0; all enables = 0; rsp_valid = 0; rsp_err = 0; timeout counter = 0. cmd_ready = 0 while RST is high. Any in-flight command is discarded. Flags arriving after reset release in IDLE are ignored.
- cmd_ready = (state == IDLE) & ~RST. It is 0 in all other states.
- FSM states:
  - IDLE: on cmd_valid, latch cmd_A/cmd_B/cmd_OP into A/B/OP and latch cmd_unit, then go to ISSUE.
  - ISSUE: exactly one cycle. The enable of the latched unit is 1; all others are 0. Go to WAIT with counter = 0.
  - WAIT: all enables are 0.
    - If the selected unit's flag = 1: rsp_data <= that unit's out, rsp_err <= 0, go to RESP.
    - Else counter++. When the counter reaches TIMEOUT (the TIMEOUT-th WAIT cycle without a flag): rsp_data <= 0, rsp_err <= 1, go to RESP.
    - A flag in the same cycle as expiry wins (no error).
  - RESP: rsp_valid = 1. rsp_data and rsp_err are held stable until rsp_ready. On rsp_ready, go to IDLE.
- Enables are registered outputs, so they are glitch-free. Each enable pulses for exactly 1 cycle per command.
- A/B/OP stay stable from acceptance until the next acceptance, so units see stable operands during ISSUE.
- Flags from non-selected units are ignored in every state.
- Latency with a standard unit (flag 1 cycle after enable):
  - Accept at edge N, ISSUE during N+1, flag seen in WAIT at N+2, rsp_valid from N+3.
  - Minimum 4 cycles per command with rsp_ready held high. No pipelining: one command in flight.
- Counter width = $clog2(TIMEOUT+1). The counter never wraps; it is cleared on entry to WAIT.
- If rsp_ready is high in a cycle where rsp_valid is 0, it has no effect.

Test Plan:
1. Logic AND with a real logic unit attached: A=0x00FF, B=0x0F0F, unit=01, OP=00, accept at edge N -> logic_enable high only during N+1; rsp_valid rises at N+3 with rsp_data=0x000F, rsp_err=0; other enables stay 0 throughout.
2. Backpressure: hold rsp_ready=0 for 5 cycles in RESP with cmd_valid=1 -> rsp_valid, rsp_data, rsp_err stable and cmd_ready=0; the second command is accepted only on the edge after rsp_ready=1.
3. Timeout: cmp_flag tied 0, TIMEOUT=7, unit=10 accepted at N -> 7 WAIT cycles (N+2..N+8), rsp_valid at N+9 with rsp_err=1, rsp_data=0.
4. Late flag: stub shift unit raises shift_flag with shift_out=0x1234 on the 7th WAIT cycle (TIMEOUT=7) -> rsp_err=0, rsp_data=0x1234.
5. Reset mid-WAIT: assert RST async during WAIT -> all outputs 0 immediately; after release cmd_ready=1 and a late arith_flag produces no response.
6. Back-to-back, rsp_ready=1, logic OR 0xA000|0x0005 then NOR 0x0000,0x0000 -> responses 0xA005 then 0xFFFF, 4 cycles apart; a spurious arith_flag pulse during the logic WAIT is ignored.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command, operand-bus, unit and response signals of the ALU issue controller
//
// Purpose: bundles every non-clock/reset signal of alu_issue_ctrl.
//   master : the issue controller (drives cmd_ready, A/B/OP, enables, rsp_*)
//   slave  : the environment (command source, functional units, response sink)
// Signals:
//   cmd_valid/cmd_ready/cmd_A/cmd_B/cmd_unit/cmd_OP : command handshake
//   A/B/OP                                           : shared operand bus
//   <unit>_enable/<unit>_out/<unit>_flag             : per-unit enable, result, result-valid
//   rsp_valid/rsp_ready/rsp_data/rsp_err             : response handshake
interface alu_issue_ctrl_if #(
    parameter int in_width  = 16,
    parameter int out_width = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [in_width-1:0]  cmd_A;
    logic [in_width-1:0]  cmd_B;
    logic [1:0]           cmd_unit;
    logic [1:0]           cmd_OP;

    logic [in_width-1:0]  A;
    logic [in_width-1:0]  B;
    logic [1:0]           OP;

    logic                 arith_enable;
    logic                 logic_enable;
    logic                 cmp_enable;
    logic                 shift_enable;

    logic [out_width-1:0] arith_out;
    logic [out_width-1:0] logic_out;
    logic [out_width-1:0] cmp_out;
    logic [out_width-1:0] shift_out;

    logic                 arith_flag;
    logic                 logic_flag;
    logic                 cmp_flag;
    logic                 shift_flag;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [out_width-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        input  cmd_valid, cmd_A, cmd_B, cmd_unit, cmd_OP,
        output cmd_ready,
        output A, B, OP,
        output arith_enable, logic_enable, cmp_enable, shift_enable,
        input  arith_out, logic_out, cmp_out, shift_out,
        input  arith_flag, logic_flag, cmp_flag, shift_flag,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_A, cmd_B, cmd_unit, cmd_OP,
        input  cmd_ready,
        input  A, B, OP,
        input  arith_enable, logic_enable, cmp_enable, shift_enable,
        output arith_out, logic_out, cmp_out, shift_out,
        output arith_flag, logic_flag, cmp_flag, shift_flag,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-outstanding command issuer for the ALU functional units
//
// Purpose: accepts one command, drives A/B/OP, pulses exactly one unit enable for one
// cycle, waits up to TIMEOUT cycles for that unit's result flag and returns the captured
// result (or a timeout error with zero data) on the response handshake.
// Ports:
//   CLK : clock, all flops on posedge
//   RST : asynchronous active-high reset
//   bus : alu_issue_ctrl_if master modport (command, operand bus, units, response)
module alu_issue_ctrl #(
    parameter int in_width  = 16,
    parameter int out_width = 16,
    parameter int TIMEOUT   = 7
) (
    input  logic             CLK,
    input  logic             RST,
    alu_issue_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           unit_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [in_width-1:0]  a_q;
    logic [in_width-1:0]  b_q;
    logic [1:0]           op_q;
    logic [3:0]           en_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [out_width-1:0] rsp_data_q;

    logic                 sel_flag;
    logic [out_width-1:0] sel_out;

    // Only the latched unit's flag/result is looked at; the others are don't-care.
    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (unit_q)
            2'b00: begin sel_flag = bus.arith_flag; sel_out = bus.arith_out; end
            2'b01: begin sel_flag = bus.logic_flag; sel_out = bus.logic_out; end
            2'b10: begin sel_flag = bus.cmp_flag;   sel_out = bus.cmp_out;   end
            default: begin sel_flag = bus.shift_flag; sel_out = bus.shift_out; end
        endcase
    end

    // cnt_q stays below TIMEOUT while in WAIT, so the increment always fits in CW bits.
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            unit_q      <= 2'b00;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'b00;
            en_q        <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        a_q     <= bus.cmd_A;
                        b_q     <= bus.cmd_B;
                        op_q    <= bus.cmd_OP;
                        unit_q  <= bus.cmd_unit;
                        // Enable is set here so it is high exactly during ISSUE.
                        en_q    <= 4'b0001 << bus.cmd_unit;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    en_q    <= 4'b0000;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Flag is checked first so a flag on the expiry cycle wins.
                    if (sel_flag) begin
                        rsp_data_q  <= sel_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_d == TIMEOUT_VAL) begin
                        cnt_q       <= cnt_d;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gated by RST directly so the source sees not-ready during the whole reset pulse.
    assign bus.cmd_ready    = (state_q == IDLE) && !RST;

    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.OP           = op_q;

    assign bus.arith_enable = en_q[0];
    assign bus.logic_enable = en_q[1];
    assign bus.cmp_enable   = en_q[2];
    assign bus.shift_enable = en_q[3];

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;
    logic [16:0] exp_q[$];

    alu_issue_ctrl_if #(.in_width(16), .out_width(16)) bus ();

    alu_issue_ctrl #(.in_width(16), .out_width(16), .TIMEOUT(7)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Real logic unit: registered result and flag one cycle after its enable.
    function automatic logic [15:0] logic_fn(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.logic_flag <= 1'b0;
            bus.logic_out  <= 16'h0;
        end else begin
            bus.logic_flag <= bus.logic_enable;
            if (bus.logic_enable) bus.logic_out <= logic_fn(bus.A, bus.B, bus.OP);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] unit, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_data, input logic exp_err);
        bus.cmd_unit  = unit;
        bus.cmd_OP    = op;
        bus.cmd_A     = a;
        bus.cmd_B     = b;
        bus.cmd_valid = 1'b1;
        exp_q.push_back({exp_err, exp_data});
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int cyc);
        logic [16:0] e;
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(bus.rsp_data), 32'(e[15:0]));
            chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e[16]));
        end
    endtask

    initial begin
        int cyc;
        int t1;
        int t2;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_A     = 16'h0;
        bus.cmd_B     = 16'h0;
        bus.cmd_unit  = 2'b00;
        bus.cmd_OP    = 2'b00;
        bus.rsp_ready = 1'b0;
        bus.arith_out = 16'h0;
        bus.cmp_out   = 16'h0;
        bus.shift_out = 16'h0;
        bus.arith_flag = 1'b0;
        bus.cmp_flag   = 1'b0;
        bus.shift_flag = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_A", 32'(bus.A), 32'd0);
        chk("rst_en", 32'({bus.arith_enable, bus.logic_enable, bus.cmp_enable, bus.shift_enable}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // 1: logic AND, standard latency
        bus.rsp_ready = 1'b1;
        send(2'b01, 2'b00, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
        chk("t1_issue_en", 32'({bus.arith_enable, bus.logic_enable, bus.cmp_enable, bus.shift_enable}), 32'b0100);
        chk("t1_A", 32'(bus.A), 32'h00FF);
        chk("t1_B", 32'(bus.B), 32'h0F0F);
        chk("t1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("t1_wait_en", 32'({bus.arith_enable, bus.logic_enable, bus.cmp_enable, bus.shift_enable}), 32'd0);
        chk("t1_wait_valid", 32'(bus.rsp_valid), 32'd0);
        wait_rsp("t1", cyc);
        chk("t1_latency", 32'(cyc), 32'd1);
        tick();
        chk("t1_idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t1_idle_valid", 32'(bus.rsp_valid), 32'd0);

        // 2: backpressure in RESP with a pending command
        bus.rsp_ready = 1'b0;
        send(2'b01, 2'b10, 16'h1234, 16'h00FF, 16'h12CB, 1'b0);
        wait_rsp("t2a", cyc);
        chk("t2a_latency", 32'(cyc), 32'd2);
        bus.cmd_unit  = 2'b01;
        bus.cmd_OP    = 2'b00;
        bus.cmd_A     = 16'hFFFF;
        bus.cmd_B     = 16'h5555;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t2_hold_data", 32'(bus.rsp_data), 32'h12CB);
            chk("t2_hold_err", 32'(bus.rsp_err), 32'd0);
            chk("t2_hold_ready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        chk("t2_rel_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("t2_idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t2_idle_valid", 32'(bus.rsp_valid), 32'd0);
        exp_q.push_back({1'b0, 16'h5555});
        tick();
        bus.cmd_valid = 1'b0;
        chk("t2b_issue_en", 32'(bus.logic_enable), 32'd1);
        chk("t2b_A", 32'(bus.A), 32'hFFFF);
        wait_rsp("t2b", cyc);
        tick();

        // 3: timeout on cmp unit
        send(2'b10, 2'b00, 16'h0003, 16'h0004, 16'h0000, 1'b1);
        chk("t3_issue_en", 32'({bus.arith_enable, bus.logic_enable, bus.cmp_enable, bus.shift_enable}), 32'b0010);
        wait_rsp("t3", cyc);
        chk("t3_latency", 32'(cyc), 32'd8);
        tick();

        // 4: flag on the 7th WAIT cycle wins over expiry
        bus.shift_out = 16'h1234;
        send(2'b11, 2'b01, 16'h0001, 16'h0002, 16'h1234, 1'b0);
        chk("t4_issue_en", 32'({bus.arith_enable, bus.logic_enable, bus.cmp_enable, bus.shift_enable}), 32'b0001);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t4_wait_valid", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("t4_w7_valid", 32'(bus.rsp_valid), 32'd0);
        bus.shift_flag = 1'b1;
        tick();
        wait_rsp("t4", cyc);
        chk("t4_latency", 32'(cyc), 32'd0);
        bus.shift_flag = 1'b0;
        tick();

        // 5: async reset during WAIT, late flag ignored
        bus.arith_out = 16'hBEEF;
        send(2'b00, 2'b11, 16'h5A5A, 16'hA5A5, 16'h0000, 1'b0);
        void'(exp_q.pop_back());
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_A", 32'(bus.A), 32'd0);
        chk("t5_B", 32'(bus.B), 32'd0);
        chk("t5_OP", 32'(bus.OP), 32'd0);
        chk("t5_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_data", 32'(bus.rsp_data), 32'd0);
        chk("t5_err", 32'(bus.rsp_err), 32'd0);
        chk("t5_en", 32'({bus.arith_enable, bus.logic_enable, bus.cmp_enable, bus.shift_enable}), 32'd0);
        chk("t5_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_rel_ready", 32'(bus.cmd_ready), 32'd1);
        bus.arith_flag = 1'b1;
        tick();
        tick();
        chk("t5_late_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_late_ready", 32'(bus.cmd_ready), 32'd1);
        bus.arith_flag = 1'b0;

        // 6: back-to-back OR then NOR, spurious arith flag during WAIT
        bus.cmd_unit  = 2'b01;
        bus.cmd_OP    = 2'b01;
        bus.cmd_A     = 16'hA000;
        bus.cmd_B     = 16'h0005;
        bus.cmd_valid = 1'b1;
        exp_q.push_back({1'b0, 16'hA005});
        tick();
        bus.cmd_OP = 2'b11;
        bus.cmd_A  = 16'h0000;
        bus.cmd_B  = 16'h0000;
        exp_q.push_back({1'b0, 16'hFFFF});
        chk("t6_issue_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        bus.arith_flag = 1'b1;
        chk("t6_wait_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.arith_flag = 1'b0;
        wait_rsp("t6a", cyc);
        t1 = cyc_cnt;
        tick();
        tick();
        bus.cmd_valid = 1'b0;
        chk("t6b_issue_en", 32'(bus.logic_enable), 32'd1);
        wait_rsp("t6b", cyc);
        t2 = cyc_cnt;
        chk("t6_spacing", 32'(t2 - t1), 32'd4);
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
